// File: rtl/osd_mam_arbiter.sv
// Round-robin arbiter sharing one MAM memory port between two requesters.
// One whole transaction (request plus all data beats) is granted at a time.
module osd_mam_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    s0_req_valid,
   output logic                    s0_req_ready,
   input  logic                    s0_req_rw,
   input  logic [ADDR_WIDTH-1:0]   s0_req_addr,
   input  logic                    s0_req_burst,
   input  logic [13:0]             s0_req_size,
   input  logic                    s0_write_valid,
   output logic                    s0_write_ready,
   input  logic [DATA_WIDTH-1:0]   s0_write_data,
   input  logic [DATA_WIDTH/8-1:0] s0_write_strb,
   output logic                    s0_read_valid,
   input  logic                    s0_read_ready,
   output logic [DATA_WIDTH-1:0]   s0_read_data,

   input  logic                    s1_req_valid,
   output logic                    s1_req_ready,
   input  logic                    s1_req_rw,
   input  logic [ADDR_WIDTH-1:0]   s1_req_addr,
   input  logic                    s1_req_burst,
   input  logic [13:0]             s1_req_size,
   input  logic                    s1_write_valid,
   output logic                    s1_write_ready,
   input  logic [DATA_WIDTH-1:0]   s1_write_data,
   input  logic [DATA_WIDTH/8-1:0] s1_write_strb,
   output logic                    s1_read_valid,
   input  logic                    s1_read_ready,
   output logic [DATA_WIDTH-1:0]   s1_read_data,

   output logic                    m_req_valid,
   input  logic                    m_req_ready,
   output logic                    m_req_rw,
   output logic [ADDR_WIDTH-1:0]   m_req_addr,
   output logic                    m_req_burst,
   output logic [13:0]             m_req_size,
   output logic                    m_write_valid,
   input  logic                    m_write_ready,
   output logic [DATA_WIDTH-1:0]   m_write_data,
   output logic [DATA_WIDTH/8-1:0] m_write_strb,
   input  logic                    m_read_valid,
   output logic                    m_read_ready,
   input  logic [DATA_WIDTH-1:0]   m_read_data,

   output logic                    grant,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic [13:0] beats_q, beats_d;
   logic        rw_q, rw_d;

   logic                    sel_req_valid;
   logic                    sel_req_rw;
   logic [ADDR_WIDTH-1:0]   sel_req_addr;
   logic                    sel_req_burst;
   logic [13:0]             sel_req_size;
   logic                    sel_write_valid;
   logic [DATA_WIDTH-1:0]   sel_write_data;
   logic [DATA_WIDTH/8-1:0] sel_write_strb;
   logic                    sel_read_ready;
   logic                    beat;

   assign sel_req_valid   = grant_q ? s1_req_valid   : s0_req_valid;
   assign sel_req_rw      = grant_q ? s1_req_rw      : s0_req_rw;
   assign sel_req_addr    = grant_q ? s1_req_addr    : s0_req_addr;
   assign sel_req_burst   = grant_q ? s1_req_burst   : s0_req_burst;
   assign sel_req_size    = grant_q ? s1_req_size    : s0_req_size;
   assign sel_write_valid = grant_q ? s1_write_valid : s0_write_valid;
   assign sel_write_data  = grant_q ? s1_write_data  : s0_write_data;
   assign sel_write_strb  = grant_q ? s1_write_strb  : s0_write_strb;
   assign sel_read_ready  = grant_q ? s1_read_ready  : s0_read_ready;

   assign busy  = (state_q != IDLE);
   assign grant = grant_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         beats_q <= '0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beats_q <= beats_d;
         rw_q    <= rw_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beats_d = beats_q;
      rw_d    = rw_q;
      beat    = 1'b0;

      s0_req_ready   = 1'b0;
      s1_req_ready   = 1'b0;
      s0_write_ready = 1'b0;
      s1_write_ready = 1'b0;
      s0_read_valid  = 1'b0;
      s1_read_valid  = 1'b0;
      s0_read_data   = '0;
      s1_read_data   = '0;
      m_req_valid    = 1'b0;
      m_req_rw       = 1'b0;
      m_req_addr     = '0;
      m_req_burst    = 1'b0;
      m_req_size     = '0;
      m_write_valid  = 1'b0;
      m_write_data   = '0;
      m_write_strb   = '0;
      m_read_ready   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (s0_req_valid || s1_req_valid) begin
               // On a tie the port that did not win last time goes first
               grant_d = (s0_req_valid && s1_req_valid) ? ~last_q
                                                        : s1_req_valid;
               state_d = REQ;
            end
         end
         REQ: begin
            m_req_valid = sel_req_valid;
            m_req_rw    = sel_req_rw;
            m_req_addr  = sel_req_addr;
            m_req_burst = sel_req_burst;
            m_req_size  = sel_req_size;
            if (grant_q) s1_req_ready = m_req_ready;
            else         s0_req_ready = m_req_ready;
            if (sel_req_valid && m_req_ready) begin
               rw_d    = sel_req_rw;
               beats_d = (sel_req_burst && sel_req_size != '0)
                         ? sel_req_size : 14'd1;
               last_d  = grant_q;
               state_d = DATA;
            end
         end
         DATA: begin
            if (rw_q) begin
               m_write_valid = sel_write_valid;
               m_write_data  = sel_write_data;
               m_write_strb  = sel_write_strb;
               if (grant_q) s1_write_ready = m_write_ready;
               else         s0_write_ready = m_write_ready;
               beat = sel_write_valid && m_write_ready;
            end else begin
               m_read_ready = sel_read_ready;
               if (grant_q) begin
                  s1_read_valid = m_read_valid;
                  s1_read_data  = m_read_data;
               end else begin
                  s0_read_valid = m_read_valid;
                  s0_read_data  = m_read_data;
               end
               beat = m_read_valid && sel_read_ready;
            end
            if (beat) begin
               if (beats_q <= 14'd1) begin
                  beats_d = '0;
                  state_d = IDLE;
               end else begin
                  beats_d = beats_q - 14'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
